// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
// Serial frame transmitter. A parallel word taken over a valid/ready
// handshake is sent on a 1-bit line as: sync preamble (MSB-first), payload
// (MSB-first), then GAP_CYC idle-high cycles. The line idles high so the
// preamble is the only deliberate sync pattern a downstream detector sees.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous, active-low reset
//   tx_valid   - tx_data holds a word to send
//   tx_data    - payload word, DATA_W bits
//   tx_ready   - block accepts a word this cycle (IDLE only)
//   dout_bit   - serial line, high when idle
//   dout_valid - dout_bit carries a preamble or payload bit
//   busy       - high from acceptance until return to IDLE
//   frame_done - one-cycle pulse on the first IDLE cycle after a frame
module serial_pattern_tx #(
  parameter int               DATA_W   = 8,
  parameter int               PRE_W    = 4,
  parameter logic [PRE_W-1:0] PREAMBLE = 4'b0101,
  parameter int               GAP_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              dout_bit,
  output logic              dout_valid,
  output logic              busy,
  output logic              frame_done
);

  // The counter must hold the longest phase length without wrapping.
  localparam int MAX_A   = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_LEN = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  // GAP is unreachable when GAP_CYC==0; clamp so the constant stays legal.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              frame_done_q, frame_done_d;
  logic              pre_bit;

  // Next-state logic. frame_done_d is raised on the transition into IDLE
  // that ends a frame, so the registered pulse covers the first IDLE cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx_valid) begin
          shift_d = tx_data;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (cnt_q == PRE_LAST) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        shift_d = shift_q << 1;
        if (cnt_q == DATA_LAST) begin
          cnt_d = '0;
          if (GAP_CYC == 0) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d        = '0;
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Preamble bit select: counter value c picks PREAMBLE[PRE_W-1-c], done
  // with constant indices so the mux is explicit.
  always_comb begin
    pre_bit = 1'b1;
    for (int i = 0; i < PRE_W; i++) begin
      if (cnt_q == CNT_W'(PRE_W - 1 - i)) begin
        pre_bit = PREAMBLE[i];
      end
    end
  end

  // Moore outputs decoded from state, counter and shift register.
  always_comb begin
    tx_ready   = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    dout_valid = (state_q == ST_PRE) || (state_q == ST_DATA);
    case (state_q)
      ST_PRE:  dout_bit = pre_bit;
      ST_DATA: dout_bit = shift_q[DATA_W-1];
      default: dout_bit = 1'b1;
    endcase
    frame_done = frame_done_q;
  end

  // State registers; an active reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial frame transmitter that feeds the team's serial bit-pattern detectors. It accepts a parallel word over a valid/ready handshake. It then emits the word as a frame on a 1-bit serial line: a fixed sync preamble (default 0101) first, then the data word MSB-first, then an idle gap. The line idles high between frames, so the preamble is the only deliberate sync pattern a downstream detector sees.

Parameters:
DATA_W, 8, payload width in bits (>=1)
PRE_W, 4, preamble length in bits (>=1)
PREAMBLE, 4'b0101, preamble pattern, sent MSB-first, PRE_W bits wide
GAP_CYC, 2, idle-high cycles after each frame (>=0)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
tx_valid  input  1  tx_data holds a word to send
tx_data  input  DATA_W  payload word
tx_ready  output  1  block can accept a word this cycle
dout_bit  output  1  serial line, idles high
dout_valid  output  1  high while dout_bit carries a preamble or data bit
busy  output  1  high from acceptance until return to IDLE
frame_done  output  1  one-cycle pulse on the first IDLE cycle after a frame

Behaviour:
- Reset (rst==0 at a rising edge):
  - State becomes IDLE and the shift and bit counters clear.
  - Outputs: dout_bit=1, dout_valid=0, tx_ready=1, busy=0, frame_done=0.
  - Reset mid-frame aborts the frame with no frame_done pulse.
- States: IDLE, PREAMBLE, DATA, GAP. Moore style: outputs decode from state, counter and shift register only.
- IDLE:
  - tx_ready=1, dout_bit=1, dout_valid=0.
  - When tx_valid&&tx_ready at an edge, tx_data latches into the shift register, the counter loads 0 and the state moves to PREAMBLE.
- PREAMBLE:
  - Lasts PRE_W cycles. dout_bit=PREAMBLE[PRE_W-1-cnt], dout_valid=1.
  - After the last bit, the state moves to DATA with the counter at 0.
- DATA:
  - Lasts DATA_W cycles. dout_bit=shift MSB, dout_valid=1.
  - The shift register moves left by one each cycle.
  - After the last bit, the state moves to GAP, or straight to IDLE if GAP_CYC==0.
- GAP:
  - Lasts GAP_CYC cycles. dout_bit=1, dout_valid=0.
  - After the last cycle, the state moves to IDLE.
- Timing:
  - Handshake at edge k: the first preamble bit is visible right after edge k.
  - The last data bit ends at edge k+PRE_W+DATA_W.
  - IDLE is re-entered at edge k+PRE_W+DATA_W+GAP_CYC.
- frame_done: registered, high for exactly the first IDLE cycle after a completed frame.
- busy = (state!=IDLE). tx_ready = (state==IDLE), never asserted in other states.
- tx_valid/tx_data outside IDLE are ignored; the latched word is unaffected by later tx_data changes.
- With tx_valid held high, frames repeat every PRE_W+DATA_W+GAP_CYC+1 cycles. There is at least one IDLE cycle between frames, and that cycle accepts the next word.
- Counter width is $clog2 of max(PRE_W,DATA_W,GAP_CYC)+1. The counter never wraps inside a state and resets to 0 on every state change.
- Unused state encodings recover to IDLE on the next edge.

Test Plan:
1. Reset: hold rst=0 for 3 edges with tx_valid=1 -> dout_bit=1, dout_valid=0, tx_ready=1, busy=0, frame_done=0 throughout; no word accepted.
2. Single frame, tx_data=8'hA5, one-cycle tx_valid -> dout_bit sequence 0,1,0,1,1,0,1,0,0,1,0,1 with dout_valid=1 for all 12 cycles. Then 2 cycles of dout_bit=1, dout_valid=0. Then frame_done=1 for one cycle, tx_ready=1.
3. Back-to-back, tx_valid held high, tx_data=8'hFF then 8'h00 -> second preamble starts exactly 15 cycles after the first. Payload 11111111 followed by 00000000, each after 0101.
4. Busy ignore: after accepting 8'h3C, drive tx_data=8'hC3 with tx_valid=1 during the frame -> payload 00111100 is sent; tx_ready=0 until IDLE; 8'hC3 is accepted only in the next IDLE cycle.
5. Reset mid-frame: rst=0 during data bit 3 -> next edge gives dout_bit=1, dout_valid=0, busy=0, and no frame_done pulse. A new 8'h5A frame then transmits intact.
6. Parameter variant GAP_CYC=0, DATA_W=4, tx_data=4'h9 -> sequence 0101 1001, then IDLE immediately with frame_done pulse; frame period is 9 cycles.
